// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, register map offsets and status bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [7:0] TXDB  = 8'h00;
    localparam logic [7:0] RXDB  = 8'h01;
    localparam logic [7:0] UBRR  = 8'h02;
    localparam logic [7:0] CTRL0 = 8'h03;
    localparam logic [7:0] CTRL1 = 8'h04;
    localparam logic [7:0] STAT  = 8'h05;

    localparam int STAT_RXC  = 0;
    localparam int STAT_TXC  = 1;
    localparam int STAT_UDRE = 2;

    function automatic logic frame_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: latches the divisor on restart and emits a one-cycle tick every div+1 cycles.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             pClk,
    input  logic             pReset,
    input  logic             i_restart,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == r_div);
    assign o_tick = i_en && w_wrap;

    // Divisor is sampled only at restart so mid-frame Ubrr writes cannot stretch a bit.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_restart) begin
            r_div <= i_div;
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: double-buffered byte path, frame sequencing and UDRE/TXC/DOR status.
// Define UART_TX_PARITY_EN to insert a parity bit between the data bits and the stop bit(s).
module uart_tx_ctrl #(
    parameter int DIV_W      = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             pClk,
    input  logic             pReset,
    input  logic             TxWr,
    input  logic [7:0]       TxData,
    input  logic [DIV_W-1:0] Ubrr,
    input  logic             TxEn,
    input  logic             TxcClr,
    output logic             Txd,
    output logic             Udre,
    output logic             Txc,
    output logic             Dor,
    output logic             Busy
);
    import uart_pkg::*;

    if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_err
        $error("uart_tx_ctrl: STOP_BITS must be 1 or 2 and PARITY_ODD 0 or 1");
    end

    tx_state_e  r_state;
    logic [7:0] r_hold;
    logic       r_hold_vld;
    logic [7:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_stopcnt;
    logic       r_txd;
    logic       r_udre;
    logic       r_txc;
    logic       r_dor;
    logic       r_busy;
`ifdef UART_TX_PARITY_EN
    logic       r_par;
`endif

    logic w_tick;
    logic w_wr_acc;
    logic w_frame_end;
    logic w_load;
    logic w_txc_set;

    assign w_wr_acc    = TxWr && r_udre;
    assign w_frame_end = (r_state == STOP) && w_tick && (r_stopcnt == 1'(STOP_BITS - 1));
    assign w_load      = r_hold_vld && TxEn && ((r_state == IDLE) || w_frame_end);
    assign w_txc_set   = w_frame_end && !w_load;

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud (
        .pClk      (pClk),
        .pReset    (pReset),
        .i_restart (w_load),
        .i_en      (r_busy),
        .i_div     (Ubrr),
        .o_tick    (w_tick)
    );

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_stopcnt  <= 1'b0;
            r_txd      <= 1'b1;
            r_udre     <= 1'b1;
            r_txc      <= 1'b0;
            r_dor      <= 1'b0;
            r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_dor <= TxWr && !r_udre;

            // A frame ending in the same cycle as a clear request still reports completion.
            if (w_txc_set)
                r_txc <= 1'b1;
            else if (TxcClr || w_wr_acc)
                r_txc <= 1'b0;

            if (w_wr_acc) begin
                r_hold     <= TxData;
                r_hold_vld <= 1'b1;
                r_udre     <= 1'b0;
            end

            if (w_load) begin
                r_shift    <= r_hold;
                r_hold_vld <= 1'b0;
                r_udre     <= 1'b1;
                r_txd      <= 1'b0;
                r_busy     <= 1'b1;
                r_bitcnt   <= '0;
                r_stopcnt  <= 1'b0;
                r_state    <= START;
`ifdef UART_TX_PARITY_EN
                r_par      <= frame_parity(r_hold, 1'(PARITY_ODD));
`endif
            end else begin
                case (r_state)
                    IDLE: ;
                    START: if (w_tick) begin
                        r_txd    <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bitcnt <= '0;
                        r_state  <= DATA;
                    end
                    DATA: if (w_tick) begin
                        if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_txd     <= r_par;
                            r_state   <= PARITY;
`else
                            r_txd     <= 1'b1;
                            r_stopcnt <= 1'b0;
                            r_state   <= STOP;
`endif
                        end else begin
                            r_txd    <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                    PARITY: if (w_tick) begin
                        r_txd     <= 1'b1;
                        r_stopcnt <= 1'b0;
                        r_state   <= STOP;
                    end
                    STOP: if (w_tick) begin
                        if (w_frame_end) begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_stopcnt <= r_stopcnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign Txd  = r_txd;
    assign Udre = r_udre;
    assign Txc  = r_txc;
    assign Dor  = r_dor;
    assign Busy = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl (default parameters; parity frame when UART_TX_PARITY_EN is set).
module tb_uart_tx_ctrl;

    localparam logic PAR_ODD = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        TxWr = 1'b0;
    logic [7:0]  TxData = 8'h00;
    logic [15:0] Ubrr = 16'd3;
    logic        TxEn = 1'b0;
    logic        TxcClr = 1'b0;
    logic        Txd, Udre, Txc, Dor, Busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl dut (
        .pClk   (clk),
        .pReset (rst_n),
        .TxWr   (TxWr),
        .TxData (TxData),
        .Ubrr   (Ubrr),
        .TxEn   (TxEn),
        .TxcClr (TxcClr),
        .Txd    (Txd),
        .Udre   (Udre),
        .Txc    (Txc),
        .Dor    (Dor),
        .Busy   (Busy)
    );

    // Called on the negedge right after the start-bit edge; checks every cycle of the frame.
    task automatic check_frame(input logic [7:0] d, input int div, input string tag);
        logic [11:0] f;
        int nbits;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        nbits = 10;
`ifdef UART_TX_PARITY_EN
        f[9]  = (^d) ^ PAR_ODD;
        f[10] = 1'b1;
        nbits = 11;
`endif
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c <= div; c++) begin
                checks++;
                if (Txd !== f[b]) begin
                    errors++;
                    $display("FAIL %s bit%0d cyc%0d Txd=%b expected=%b", tag, b, c, Txd, f[b]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({Txd, Udre, Txc, Dor, Busy} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_state got=%b expected=11000", {Txd, Udre, Txc, Dor, Busy});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({Txd, Udre, Txc, Dor, Busy} !== 5'b11000) begin
            errors++;
            $display("FAIL post_reset_idle got=%b expected=11000", {Txd, Udre, Txc, Dor, Busy});
        end
    endtask

    task automatic test_single_byte();
        Ubrr = 16'd3;
        TxEn = 1'b1;
        TxWr = 1'b1;
        TxData = 8'hA5;
        @(negedge clk);
        TxWr = 1'b0;
        checks++;
        if ({Udre, Busy, Txd} !== 3'b001) begin
            errors++;
            $display("FAIL single_after_write {Udre,Busy,Txd}=%b expected=001", {Udre, Busy, Txd});
        end
        @(negedge clk);
        checks++;
        if ({Udre, Busy} !== 2'b11) begin
            errors++;
            $display("FAIL single_udre_2cyc {Udre,Busy}=%b expected=11", {Udre, Busy});
        end
        check_frame(8'hA5, 3, "single_A5");
        checks++;
        if ({Txd, Busy, Txc, Udre} !== 4'b1011) begin
            errors++;
            $display("FAIL single_end {Txd,Busy,Txc,Udre}=%b expected=1011", {Txd, Busy, Txc, Udre});
        end
        TxcClr = 1'b1;
        @(negedge clk);
        TxcClr = 1'b0;
        checks++;
        if (Txc !== 1'b0) begin
            errors++;
            $display("FAIL txc_clear Txc=%b expected=0", Txc);
        end
    endtask

    task automatic test_zero_div();
        Ubrr = 16'd0;
        TxWr = 1'b1;
        TxData = 8'h96;
        @(negedge clk);
        TxWr = 1'b0;
        @(negedge clk);
        check_frame(8'h96, 0, "div0_96");
        checks++;
        if ({Busy, Txc} !== 2'b01) begin
            errors++;
            $display("FAIL div0_end {Busy,Txc}=%b expected=01", {Busy, Txc});
        end
        Ubrr = 16'd3;
    endtask

    task automatic test_back_to_back();
        TxWr = 1'b1;
        TxData = 8'h55;
        @(negedge clk);
        TxWr = 1'b0;
        checks++;
        if (Txc !== 1'b0) begin
            errors++;
            $display("FAIL b2b_txc_clr_on_write Txc=%b expected=0", Txc);
        end
        @(negedge clk);
        fork
            check_frame(8'h55, 3, "b2b_55");
            begin
                repeat (8) @(negedge clk);
                TxWr = 1'b1;
                TxData = 8'h0F;
                @(negedge clk);
                TxWr = 1'b0;
                checks++;
                if (Udre !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_udre_held Udre=%b expected=0", Udre);
                end
            end
        join
        checks++;
        if ({Busy, Txc} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_between {Busy,Txc}=%b expected=10", {Busy, Txc});
        end
        check_frame(8'h0F, 3, "b2b_0F");
        checks++;
        if ({Busy, Txc} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_end {Busy,Txc}=%b expected=01", {Busy, Txc});
        end
    endtask

    task automatic test_overrun();
        int lows;
        TxWr = 1'b1;
        TxData = 8'h11;
        @(negedge clk);
        TxWr = 1'b0;
        @(negedge clk);
        fork
            check_frame(8'h11, 3, "ovr_11");
            begin
                TxWr = 1'b1;
                TxData = 8'h22;
                @(negedge clk);
                checks++;
                if ({Dor, Udre} !== 2'b00) begin
                    errors++;
                    $display("FAIL ovr_accept {Dor,Udre}=%b expected=00", {Dor, Udre});
                end
                TxData = 8'h33;
                @(negedge clk);
                TxWr = 1'b0;
                checks++;
                if (Dor !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_dor_pulse Dor=%b expected=1", Dor);
                end
                @(negedge clk);
                checks++;
                if (Dor !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_dor_one_cycle Dor=%b expected=0", Dor);
                end
            end
        join
        check_frame(8'h22, 3, "ovr_22");
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            if (Txd !== 1'b1 || Busy !== 1'b0) lows++;
            @(negedge clk);
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL ovr_no_third_frame active_cycles=%0d expected=0", lows);
        end
    endtask

    task automatic test_divisor_change();
        Ubrr = 16'd3;
        TxWr = 1'b1;
        TxData = 8'hC3;
        @(negedge clk);
        TxWr = 1'b0;
        @(negedge clk);
        fork
            check_frame(8'hC3, 3, "div_C3");
            begin
                repeat (10) @(negedge clk);
                Ubrr = 16'd7;
                TxWr = 1'b1;
                TxData = 8'h3C;
                @(negedge clk);
                TxWr = 1'b0;
            end
        join
        check_frame(8'h3C, 7, "div_3C");
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL div_end Busy=%b expected=0", Busy);
        end
        Ubrr = 16'd3;
    endtask

    task automatic test_txen_gate();
        TxEn = 1'b0;
        TxWr = 1'b1;
        TxData = 8'h5A;
        @(negedge clk);
        TxWr = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({Busy, Txd, Udre} !== 3'b010) begin
            errors++;
            $display("FAIL txen_hold {Busy,Txd,Udre}=%b expected=010", {Busy, Txd, Udre});
        end
        TxEn = 1'b1;
        @(negedge clk);
        fork
            check_frame(8'h5A, 3, "txen_5A");
            begin
                repeat (8) @(negedge clk);
                TxWr = 1'b1;
                TxData = 8'hE1;
                @(negedge clk);
                TxWr = 1'b0;
                TxEn = 1'b0;
            end
        join
        repeat (6) @(negedge clk);
        checks++;
        if ({Busy, Txd, Udre} !== 3'b010) begin
            errors++;
            $display("FAIL txen_pending_kept {Busy,Txd,Udre}=%b expected=010", {Busy, Txd, Udre});
        end
        TxEn = 1'b1;
        @(negedge clk);
        check_frame(8'hE1, 3, "txen_E1");
    endtask

    task automatic test_reset_mid();
        int active;
        TxWr = 1'b1;
        TxData = 8'h00;
        @(negedge clk);
        TxWr = 1'b0;
        @(negedge clk);
        TxWr = 1'b1;
        TxData = 8'h00;
        @(negedge clk);
        TxWr = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if ({Txd, Udre, Busy} !== 3'b001) begin
            errors++;
            $display("FAIL rst_mid_pre {Txd,Udre,Busy}=%b expected=001", {Txd, Udre, Busy});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({Txd, Udre, Txc, Dor, Busy} !== 5'b11000) begin
            errors++;
            $display("FAIL rst_mid_async got=%b expected=11000", {Txd, Udre, Txc, Dor, Busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        active = 0;
        for (int i = 0; i < 60; i++) begin
            if (Txd !== 1'b1 || Busy !== 1'b0 || Udre !== 1'b1) active++;
            @(negedge clk);
        end
        checks++;
        if (active != 0) begin
            errors++;
            $display("FAIL rst_no_residual active_cycles=%0d expected=0", active);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        TxWr = 1'b1;
        TxData = 8'h07;
        @(negedge clk);
        TxWr = 1'b0;
        @(negedge clk);
        check_frame(8'h07, 3, "parity_07");
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_zero_div();
        test_back_to_back();
        test_overrun();
        test_divisor_change();
        test_txen_gate();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
